i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h2A: 7-bit device address matched after START.
REQ-002 SHALL have parameter NUM_REGS, default 4, legal 1..16: number of 8-bit registers.
REQ-003 SHALL have parameter PTR_W, default 4: register-pointer width; NUM_REGS <= 2**PTR_W.
REQ-004 SHALL have port clk  input  1: single system clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port ena  input  1: enable; while 0, sda_oe = 0 and the FSM is held in IDLE.
REQ-007 SHALL have port scl_in  input  1: raw SCL pin, asynchronous to clk.
REQ-008 SHALL have port sda_in  input  1: raw SDA pin, asynchronous to clk.
REQ-009 SHALL have port sda_oe  output  1: 1 = pull SDA low (open drain); SDA output data is constant 0.
REQ-010 SHALL have port reg_out  output  8*NUM_REGS: flat register image, register i at bits [8i+7:8i].
REQ-011 SHALL have port wr_strobe  output  1: one-clk pulse when a data byte is committed.
REQ-012 SHALL have port wr_index  output  PTR_W: register index of the last committed byte.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-FF synchronisers, then a 1-FF delay for edge detection; clk >= 10x SCL required.
REQ-014 SHALL detect START on synced SDA 1->0 while synced SCL = 1, and STOP on SDA 0->1 while SCL = 1, in any state.
REQ-015 SHALL sample SDA on synced SCL rising edge, MSB first, and update sda_oe in the clk after a synced SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
REQ-017 START from any state SHALL go to ADDR with bit counter 0; STOP from any state SHALL go to IDLE with sda_oe = 0.
REQ-018 ADDR: after 8 bits, address match goes to ADDR_ACK, mismatch goes to WAIT (no ACK, bus ignored until START/STOP).
REQ-019 ADDR_ACK: sda_oe = 1 for the 9th SCL clock; next is PTR if R/W = 0, RDATA if R/W = 1.
REQ-020 PTR: received byte < NUM_REGS loads pointer and ACKs, next WDATA; otherwise NACK (sda_oe = 0), next WAIT, pointer unchanged.
REQ-021 WDATA: after 8 bits, write byte to reg[pointer], pulse wr_strobe in the same clk, wr_index = pointer, ACK, then pointer increments.
REQ-022 Pointer increment SHALL wrap NUM_REGS-1 -> 0.
REQ-023 RDATA: load reg[pointer] into shift register on entry; drive sda_oe = ~bit during SCL low for 8 bits; release SDA for the 9th clock (RDATA_ACK).
REQ-024 RDATA_ACK: master ACK (SDA = 0) increments pointer (wrap) and returns to RDATA; master NACK goes to WAIT.
REQ-025 Repeated START after PTR_ACK SHALL keep the pointer, enabling write-pointer-then-read.
REQ-026 START or STOP mid-byte SHALL discard the partial byte; no register write, no wr_strobe.
REQ-027 reg_out SHALL change only on committed WDATA bytes.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, sda_oe = 0, wr_strobe = 0, wr_index = 0, pointer = 0, all registers 8'h00, synchronisers to 1 (idle bus).
REQ-029 Reset deassertion mid-transaction SHALL leave the slave in IDLE until the next START.

Structure
REQ-030 SHALL place the FSM state enumeration and ACK/NACK bit constants in shared package i2c_pkg.
REQ-031 SHALL use one sub-module i2c_sync_edge (2-FF synchroniser plus rise/fall detect), instantiated for SCL and SDA.
REQ-032 RTL SHALL stay within 120-400 lines total.

Verification
REQ-033 Write 0x54(W), ptr 0x01, data 0xA5, STOP -> three ACKs, reg_out[15:8] = 0xA5, one wr_strobe with wr_index = 1.
REQ-034 Write ptr 0x03, data 0x11, 0x22 -> reg3 = 0x11, reg0 = 0x22 (wrap), two wr_strobe pulses.
REQ-035 Address 0x56(W) -> no ACK on 9th clock, sda_oe = 0 throughout, reg_out unchanged.
REQ-036 Write ptr 0x02, repeated START, 0x55(R), read two bytes master ACK then NACK -> SDA returns reg2 then reg3; release after NACK.
REQ-037 Ptr byte 0x07 with NUM_REGS = 4 -> NACK on 9th clock, following data ignored, pointer unchanged.
REQ-038 STOP after 4 data bits, and rst_n pulse mid-byte -> no write, IDLE, sda_oe = 0, registers after reset = 0x00.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared FSM state encoding and I2C acknowledge bit levels for the register slave.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RDATA_ACK,
      ST_WAIT
   } state_t;

   // SDA level on the 9th clock.
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for a raw bus pin plus one delay stage for rise/fall detection.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= 3'b111;  // idle I2C bus is high
      end else begin
         // NOTE: non-blocking so each stage captures the previous stage's old value.
         sr <= {sr[1:0], d};
      end
   end

   assign q    = sr[1];
   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing NUM_REGS 8-bit registers through an auto-incrementing pointer.
module i2c_reg_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h2A,
   parameter int         NUM_REGS = 4,
   parameter int         PTR_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  sda_oe,
   output logic [8*NUM_REGS-1:0] reg_out,
   output logic                  wr_strobe,
   output logic [PTR_W-1:0]      wr_index
);

   logic scl_q, scl_rise, scl_fall;
   logic sda_q, sda_rise, sda_fall;

   i2c_sync_edge u_scl_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (scl_in),
      .q    (scl_q),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sda_in),
      .q    (sda_q),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   logic start, stop;
   assign start = sda_fall & scl_q;
   assign stop  = sda_rise & scl_q;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_nxt;
   logic [7:0]       shift_q, shift_d, rx_byte;
   logic             rw_q, rw_d;
   logic             sda_oe_q, sda_oe_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0] wr_index_q, wr_index_d;
   logic             wr_en;
   logic [7:0]       regs [NUM_REGS];
   logic [7:0]       rd_cur, rd_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign ptr_nxt = ptr_inc(ptr_q);
   assign rx_byte = {shift_q[6:0], sda_q};

   always_comb begin
      rd_cur = '0;
      rd_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ptr_q == PTR_W'(i))   rd_cur = regs[i];
         if (ptr_nxt == PTR_W'(i)) rd_nxt = regs[i];
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path infers a latch.
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      ptr_d       = ptr_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      sda_oe_d    = sda_oe_q;
      wr_en       = 1'b0;
      wr_strobe_d = 1'b0;
      wr_index_d  = wr_index_q;

      if (!ena || stop) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
      end else if (start) begin
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA: begin
               shift_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  case (state_q)
                     ST_ADDR: begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state_d = ST_ADDR_ACK;
                           rw_d    = rx_byte[0];
                        end else begin
                           state_d = ST_WAIT;
                        end
                     end
                     ST_PTR: begin
                        if (int'(rx_byte) < NUM_REGS) begin
                           ptr_d   = PTR_W'(rx_byte);
                           state_d = ST_PTR_ACK;
                        end else begin
                           state_d = ST_WAIT;
                        end
                     end
                     ST_WDATA: begin
                        wr_en       = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_index_d  = ptr_q;
                        ptr_d       = ptr_nxt;
                        state_d     = ST_WDATA_ACK;
                     end
                     default: state_d = ST_RDATA_ACK;
                  endcase
               end
            end
            ST_ADDR_ACK: begin
               if (rw_q) begin
                  state_d = ST_RDATA;
                  shift_d = rd_cur;
               end else begin
                  state_d = ST_PTR;
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK: state_d = ST_WDATA;
            ST_RDATA_ACK: begin
               if (sda_q == I2C_NACK) begin
                  state_d = ST_WAIT;
               end else begin
                  ptr_d   = ptr_nxt;
                  shift_d = rd_nxt;
                  state_d = ST_RDATA;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         // SDA only changes while SCL is low.
         case (state_q)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_d = ~I2C_ACK;
            ST_RDATA:                              sda_oe_d = ~shift_q[7];
            default:                               sda_oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         ptr_q       <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         sda_oe_q    <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         ptr_q       <= ptr_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         sda_oe_q    <= sda_oe_d;
         wr_strobe_q <= wr_strobe_d;
         wr_index_q  <= wr_index_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is small and must read back 0 after reset, so it is reset flop by flop.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr_q == PTR_W'(i)) regs[i] <= rx_byte;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[8*g +: 8] = regs[g];
   end

   assign sda_oe    = sda_oe_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Randomised I2C master against a register-file model; responses are scored through queues.
module tb_i2c_reg_slave;

   localparam logic [6:0] DEV  = 7'h2A;
   localparam int         NREG = 4;
   localparam int         PW   = 4;
   localparam int         Q    = 50;  // quarter SCL period, 5 clk cycles

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ena = 1'b1;
   logic                scl_m = 1'b1;
   logic                sda_m = 1'b1;
   logic                sda_oe;
   logic                wr_strobe;
   logic [8*NREG-1:0]   reg_out;
   logic [PW-1:0]       wr_index;
   wire                 sda_bus = sda_m & ~sda_oe;

   i2c_reg_slave #(
      .DEV_ADDR(DEV),
      .NUM_REGS(NREG),
      .PTR_W   (PW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .scl_in   (scl_m),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .reg_out  (reg_out),
      .wr_strobe(wr_strobe),
      .wr_index (wr_index)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] m_regs [NREG];
   int         m_ptr = 0;

   logic [7:0] exp_val_q [$];
   string      exp_name_q [$];
   logic [7:0] obs_val_q [$];
   int         exp_wr_idx_q [$];
   logic [7:0] exp_wr_dat_q [$];

   int   dut_wr_cnt = 0;
   int   quiet_hits = 0;
   logic quiet = 1'b0;
   int   mon_idx;
   logic [7:0] mon_dat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Response scoreboard: ACK bits and read bytes.
   always @(negedge clk) begin
      if (obs_val_q.size() != 0 && exp_val_q.size() != 0)
         check(exp_name_q.pop_front(), obs_val_q.pop_front(), exp_val_q.pop_front());
   end

   // Register-write scoreboard and bus-quiet watcher.
   always @(negedge clk) begin
      if (rst_n && wr_strobe) begin
         dut_wr_cnt++;
         if (exp_wr_idx_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_wr_strobe: index %0d, no write expected", wr_index);
         end else begin
            mon_idx = exp_wr_idx_q.pop_front();
            mon_dat = exp_wr_dat_q.pop_front();
            check("wr_index", wr_index, mon_idx);
            check("wr_data", reg_out[8*mon_idx +: 8], mon_dat);
         end
      end
      if (quiet && sda_oe) quiet_hits++;
   end

   task automatic bit_out(input logic b);
      sda_m = b; #Q; scl_m = 1'b1; #Q; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bit_in(output logic b);
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_start;
      sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
   endtask

   task automatic bus_stop;
      sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
   endtask

   task automatic tx_byte(input logic [7:0] v, input string nm, input logic exp_bit);
      logic a;
      exp_name_q.push_back(nm);
      exp_val_q.push_back({7'd0, exp_bit});
      for (int i = 7; i >= 0; i--) bit_out(v[i]);
      bit_in(a);
      obs_val_q.push_back({7'd0, a});
   endtask

   task automatic rx_byte(input logic master_ack, input logic [7:0] exp_v);
      logic [7:0] v;
      logic       b;
      exp_name_q.push_back("rd_byte");
      exp_val_q.push_back(exp_v);
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         v[i] = b;
      end
      obs_val_q.push_back(v);
      bit_out(master_ack ? 1'b0 : 1'b1);
   endtask

   // Write transaction: address, pointer, n data bytes (data[7:0] first).
   task automatic op_write(input logic [6:0] a, input logic [7:0] p, input int n,
                           input logic [23:0] data, input bit do_stop);
      bit hit = (a == DEV);
      bit ok  = hit && (int'(p) < NREG);
      logic [7:0] d;
      quiet = !hit;
      quiet_hits = 0;
      bus_start;
      tx_byte({a, 1'b0}, "ack_addr", hit ? 1'b0 : 1'b1);
      if (hit) begin
         tx_byte(p, "ack_ptr", ok ? 1'b0 : 1'b1);
         if (ok) m_ptr = int'(p);
         for (int k = 0; k < n; k++) begin
            d = data[8*k +: 8];
            if (ok) begin
               exp_wr_idx_q.push_back(m_ptr);
               exp_wr_dat_q.push_back(d);
               m_regs[m_ptr] = d;
               m_ptr = (m_ptr + 1) % NREG;
            end
            tx_byte(d, "ack_data", ok ? 1'b0 : 1'b1);
         end
      end
      if (do_stop) bus_stop;
      if (!hit) begin
         quiet = 1'b0;
         check("addr_miss_sda_oe_cycles", quiet_hits, 0);
      end
   endtask

   // Read n bytes from the current pointer, ACK all but the last.
   task automatic op_read(input int n);
      bus_start;
      tx_byte({DEV, 1'b1}, "ack_addr_rd", 1'b0);
      for (int k = 0; k < n; k++) begin
         rx_byte(k != n - 1, m_regs[m_ptr]);
         if (k != n - 1) m_ptr = (m_ptr + 1) % NREG;
      end
      check("release_after_nack", sda_oe, 1'b0);
      bus_stop;
   endtask

   function automatic logic [8*NREG-1:0] model_image();
      logic [8*NREG-1:0] img;
      for (int k = 0; k < NREG; k++) img[8*k +: 8] = m_regs[k];
      return img;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int   c0;
      logic [8*NREG-1:0] snap;
      logic [7:0] p;
      logic a;

      for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;

      repeat (3) @(negedge clk);
      check("rst_reg_out", reg_out, 0);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_wr_index", wr_index, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single write to register 1.
      c0 = dut_wr_cnt;
      op_write(DEV, 8'h01, 1, 24'h0000A5, 1'b1);
      check("reg1_after_write", reg_out[15:8], 8'hA5);
      check("strobes_single_write", dut_wr_cnt - c0, 1);

      // Auto-increment wraps 3 -> 0.
      c0 = dut_wr_cnt;
      op_write(DEV, 8'h03, 2, 24'h002211, 1'b1);
      check("reg3_before_wrap", reg_out[31:24], 8'h11);
      check("reg0_after_wrap", reg_out[7:0], 8'h22);
      check("strobes_wrap_write", dut_wr_cnt - c0, 2);

      // Foreign address 0x56: no ACK, no drive, no change.
      snap = reg_out;
      op_write(7'h2B, 8'h00, 1, 24'h0000FF, 1'b1);
      check("reg_out_after_addr_miss", reg_out, snap);

      // Write pointer, repeated START, read two bytes.
      op_write(DEV, 8'h02, 2, 24'h003CC3, 1'b1);
      op_write(DEV, 8'h02, 0, 24'h0, 1'b0);
      op_read(2);

      // Out-of-range pointer is NACKed and leaves the pointer alone.
      snap = reg_out;
      op_write(DEV, 8'h07, 1, 24'h000099, 1'b1);
      check("reg_out_after_bad_ptr", reg_out, snap);
      op_read(1);

      // STOP after four data bits: partial byte dropped.
      c0 = dut_wr_cnt;
      bus_start;
      tx_byte({DEV, 1'b0}, "ack_addr", 1'b0);
      tx_byte(8'h00, "ack_ptr", 1'b0);
      m_ptr = 0;
      for (int i = 0; i < 4; i++) bit_out(1'($urandom));
      bus_stop;
      check("strobes_after_partial_stop", dut_wr_cnt - c0, 0);
      check("reg_out_after_partial_stop", reg_out, model_image());

      // Reset pulse mid-byte, then the rest of the byte must be ignored.
      bus_start;
      tx_byte({DEV, 1'b0}, "ack_addr", 1'b0);
      tx_byte(8'h01, "ack_ptr", 1'b0);
      for (int i = 0; i < 3; i++) bit_out(1'($urandom));
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_sda_oe", sda_oe, 0);
      check("midrst_reg_out", reg_out, 0);
      check("midrst_wr_index", wr_index, 0);
      rst_n = 1'b1;
      for (int k = 0; k < NREG; k++) m_regs[k] = 8'h00;
      m_ptr = 0;
      quiet = 1'b1;
      quiet_hits = 0;
      for (int i = 0; i < 5; i++) bit_out(1'($urandom));
      exp_name_q.push_back("ack_after_reset");
      exp_val_q.push_back(8'h01);
      bit_in(a);
      obs_val_q.push_back({7'd0, a});
      bus_stop;
      quiet = 1'b0;
      check("post_reset_sda_oe_cycles", quiet_hits, 0);
      op_read(1);

      // Randomised traffic.
      for (int it = 0; it < 20; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               p = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NREG, 255))
                                               : 8'($urandom_range(0, NREG - 1));
               op_write(DEV, p, $urandom_range(1, 3), 24'($urandom), 1'b1);
            end
            1: begin
               op_write(DEV, 8'($urandom_range(0, NREG - 1)), 0, 24'h0, 1'b0);
               op_read($urandom_range(1, 4));
            end
            2: op_read($urandom_range(1, 3));
            default: op_write(DEV ^ 7'(1 << $urandom_range(0, 6)), 8'h00, 1, 24'($urandom), 1'b1);
         endcase
      end

      repeat (10) @(negedge clk);
      check("responses_pending", exp_val_q.size(), 0);
      check("writes_pending", exp_wr_idx_q.size(), 0);
      check("final_reg_image", reg_out, model_image());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
